muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Iterative RV32M multiply/divide engine for the EX stage of the RISC-V pipeline. It sequences a shared shift-add/restoring-subtract datapath over XLEN cycles and holds the pipeline with a busy stall while an M-extension op is in flight. When the op finishes it returns the result with a one-cycle done pulse.

## Interface
- XLEN, default 32: operand/result width.
- CNTW, default $clog2(XLEN): iteration counter width.

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX holds a valid M-extension op (opcode R_T, funct7 0000001).
- flush  in  1  EX flush (branch/jump taken); cancels any op.
- func3  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srcA  in  XLEN  rs1 value, forwarded.
- srcB  in  XLEN  rs2 value, forwarded.
- busy  out  1  stall request to the hazard unit (stallF, stallD, stallE).
- done  out  1  one-cycle pulse; result is valid.
- result  out  XLEN  op result; holds until the next accepted start.

## Operation
- States: IDLE, CALC, DONE. Reset gives IDLE, count=0, busy=0, done=0, result=0.
- IDLE:
  - start=1 and flush=0 accepts the op. Latch func3 and the sign flags.
  - Signed ops latch absolute operands. MULHSU treats only srcA as signed.
  - If the op is a divide by zero or a signed overflow (DIV/REM with srcA=0x80000000, srcB=0xFFFFFFFF), the special result is loaded and the FSM goes to DONE.
  - Otherwise the FSM goes to CALC with count=0.
- CALC: one iteration per cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract giving quotient and remainder.
  - count increments each cycle. When count=XLEN-1 the FSM goes to DONE.
- DONE:
  - done=1. Sign fix-up is applied to result.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits.
  - Next state is IDLE unconditionally.
- Special results:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give srcA.
  - Overflow: DIV gives 0x80000000; REM gives 0.
- flush in CALC or DONE: the next state is IDLE, done is forced to 0 and result is not updated. flush in IDLE blocks acceptance.
- start while in CALC or DONE is ignored. The pipeline is stalled, so start stays high through the op.
- Arithmetic: every intermediate is unsigned. Negation is two's complement at XLEN width (2·XLEN for the product).

## Timing
- busy = (IDLE & start & ~flush) | CALC. It is combinational so the stall applies in the accept cycle.
- In DONE, busy=0, so the pipeline advances and the instruction captures result on that edge.
- Normal latency:
  - Accept edge at cycle 0.
  - CALC during cycles 1..XLEN.
  - done high in cycle XLEN+1 (33 for XLEN=32).
- Special-case latency: done high in cycle 1.
- Back-to-back: a start in the cycle after DONE is accepted. There is no dead cycle beyond DONE→IDLE.
- rst mid-op: the FSM drops immediately to IDLE with all outputs 0.

## Structure
- Shared package riscv_pkg holds:
  - the M func3 constants (MUL…REMU);
  - the opcode constants shared with the main decoder;
  - the state enum mds_state_t {IDLE, CALC, DONE}.
- Sub-module muldiv_datapath holds the accumulator, quotient and remainder registers, the shift/add/subtract logic and the sign fix-up. It is driven by load, step and finish strobes from the FSM in muldiv_sequencer.

## Test plan
- MUL 7×-3 (0x00000007, 0xFFFFFFFD): busy for 33 cycles, done in cycle 33, result=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → done in cycle 1, result 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/-1 → 0x80000000 in cycle 1.
- flush at cycle 10 of a MUL: next cycle is IDLE, done never pulses, result keeps its old value. A fresh start accepted the next cycle completes normally.
- rst asserted mid-CALC: outputs go to 0 asynchronously. After release, DIVU 9/3 gives result=3 in cycle 33.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and the M-extension sequencer state type.
package riscv_pkg;

  localparam logic [6:0] OP_R_T    = 7'b0110011;
  localparam logic [6:0] OP_I_T    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mds_state_t;

  function automatic logic signed_a(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return f3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift-add / restoring-subtract datapath with sign fix-up and result register.
module muldiv_datapath
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  // acc holds {high, low}: product for multiply, {remainder, quotient} for divide.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              dneg_q, dneg_d;

  logic              a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rmd, fixed;

  always_comb begin
    a_neg    = signed_a(func3) & src_a[XLEN-1];
    b_neg    = signed_b(func3) & src_b[XLEN-1];
    abs_a    = a_neg ? -src_a : src_a;
    abs_b    = b_neg ? -src_b : src_b;
    div_zero = func3[2] && (src_b == '0);
    ovf      = (func3 == F3_DIV || func3 == F3_REM) && (src_a == IntMin) && (src_b == '1);
    special  = div_zero | ovf;
  end

  always_comb begin
    acc_d    = acc_q;
    opb_d    = opb_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    dneg_d   = dneg_q;
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (load) begin
      f3_d = func3;
      opb_d = func3[2] ? abs_b : abs_a;
      neg_d = a_neg ^ b_neg;
      dneg_d = a_neg;
      if (special) begin
        // Preload the answer so the unsigned fix-up path passes it through unchanged.
        acc_d  = ovf ? {{XLEN{1'b0}}, IntMin} : {src_a, {XLEN{1'b1}}};
        neg_d  = 1'b0;
        dneg_d = 1'b0;
      end else if (func3[2]) begin
        acc_d = {{XLEN{1'b0}}, abs_a};
      end else begin
        acc_d = {{XLEN{1'b0}}, abs_b};
      end
    end else if (step) begin
      if (f3_q[2]) begin
        if (!rem_diff[XLEN]) acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                 acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rmd   = dneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fixed = prod[XLEN-1:0];
    unique case (f3_q)
      F3_MUL:                       fixed = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fixed = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fixed = quo;
      F3_REM, F3_REMU:              fixed = rmd;
    endcase
    res_d  = finish ? fixed : res_q;
    result = res_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      opb_q  <= '0;
      res_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      dneg_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      res_q  <= res_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      dneg_q <= dneg_d;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M iterative multiply/divide control FSM; stalls the pipeline while an op is in flight.
module muldiv_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mds_state_t      state_q, state_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            load, step, finish, special;

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .finish (finish),
    .func3  (func3),
    .src_a  (srcA),
    .src_b  (srcB),
    .special(special),
    .result (result)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          busy    = 1'b1;
          load    = 1'b1;
          count_d = '0;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else begin
          step    = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CNTW'(XLEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        // A flushed instruction must not see its result retire.
        if (!flush) begin
          done   = 1'b1;
          finish = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) busy = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule
